// File: rtl/burst_line_master.sv
// Cache-line bus master: one fill or write-back request becomes a single
// fixed-length burst on the word-addressed memory bus, with the line buffered locally.
module burst_line_master #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [3:0]              req_byteenable,
    input  logic [32*BURST_LEN-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_error,
    output logic [32*BURST_LEN-1:0] rsp_rdata,
    output logic [4:0]              bus_burstcount,
    output logic [31:0]             bus_writedata,
    output logic [29:0]             bus_address,
    output logic                    bus_write,
    output logic                    bus_read,
    output logic [3:0]              bus_byteenable,
    input  logic                    s_waitrequest,
    input  logic [31:0]             s_readdata,
    input  logic                    s_readdatavalid,
    input  logic                    s_writeresponsevalid,
    input  logic [1:0]              s_response
);
    localparam int unsigned    IW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned    WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [4:0]     LAST_BEAT = 5'(BURST_LEN - 1);
    localparam logic [4:0]     LEN       = 5'(BURST_LEN);
    localparam logic [WDW-1:0] WD_LAST   = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, WR_WAIT, RESP} state_t;

    state_t                     state;
    logic [BURST_LEN-1:0][31:0] line;
    logic [4:0]                 beat;
    logic [4:0]                 resp_cnt;
    logic [WDW-1:0]             wd_cnt;
    logic                       err;

    logic       cmd_acc, rd_beat, wr_beat, wr_resp, progress, err_next, wd_expire;
    logic [4:0] beat_inc, resp_inc;
    logic       unused_addr_bits;

    assign bus_burstcount   = LEN;
    assign rsp_rdata        = line;
    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        cmd_acc   = (state == RD_CMD) && !s_waitrequest;
        rd_beat   = ((state == RD_CMD) || (state == RD_DATA)) && s_readdatavalid;
        wr_beat   = (state == WR_DATA) && bus_write && !s_waitrequest;
        wr_resp   = ((state == WR_DATA) || (state == WR_WAIT)) && s_writeresponsevalid;
        progress  = cmd_acc || rd_beat || wr_beat || wr_resp;
        err_next  = err || ((rd_beat || wr_resp) && (s_response != 2'b00));
        beat_inc  = beat + 5'd1;
        resp_inc  = wr_resp ? (resp_cnt + 5'd1) : resp_cnt;
        wd_expire = (TIMEOUT != 0) && !progress && (wd_cnt == WD_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            line           <= '0;
            beat           <= '0;
            resp_cnt       <= '0;
            wd_cnt         <= '0;
            err            <= 1'b0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_error      <= 1'b0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_address    <= '0;
            bus_writedata  <= '0;
            bus_byteenable <= '0;
        end else begin
            if (state inside {RD_CMD, RD_DATA, WR_DATA, WR_WAIT})
                wd_cnt <= (progress || TIMEOUT == 0) ? '0 : wd_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line           <= req_wdata;
                        bus_address    <= req_addr[31:2];
                        bus_byteenable <= req_byteenable;
                        beat           <= '0;
                        resp_cnt       <= '0;
                        wd_cnt         <= '0;
                        err            <= 1'b0;
                        req_ready      <= 1'b0;
                        if (req_write) begin
                            state         <= WR_DATA;
                            bus_write     <= 1'b1;
                            bus_writedata <= req_wdata[31:0];
                        end else begin
                            state    <= RD_CMD;
                            bus_read <= 1'b1;
                        end
                    end
                end
                RD_CMD, RD_DATA: begin
                    // Beats are captured even in the command-accept cycle.
                    if (rd_beat) begin
                        line[beat[IW-1:0]] <= s_readdata;
                        beat               <= beat_inc;
                    end
                    err <= err_next;
                    if (cmd_acc)
                        bus_read <= 1'b0;
                    if (rd_beat && beat == LAST_BEAT) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= err_next;
                        bus_read  <= 1'b0;
                    end else if (wd_expire) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        bus_read  <= 1'b0;
                    end else if (cmd_acc) begin
                        state <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    resp_cnt <= resp_inc;
                    err      <= err_next;
                    if (wr_beat) begin
                        beat          <= beat_inc;
                        bus_writedata <= line[beat_inc[IW-1:0]];
                        if (beat == LAST_BEAT) begin
                            bus_write <= 1'b0;
                            state     <= WR_WAIT;
                        end
                    end else if (wd_expire) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        bus_write <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    resp_cnt <= resp_inc;
                    err      <= err_next;
                    // Uses the post-increment count so a final response completes this cycle.
                    if (resp_inc >= LEN) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= err_next;
                    end else if (wd_expire) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_line_master.sv
// Directed bench for burst_line_master: a stalling memory slave at byte base 0x1000
// (64 words) plus hand-computed expectations for fill, write-back, timeout, error and reset.
module tb_burst_line_master;
    localparam int unsigned BL = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr;
    logic [3:0]    req_byteenable;
    logic [127:0]  req_wdata;
    logic          rsp_valid, rsp_error;
    logic [127:0]  rsp_rdata;
    logic [4:0]    bus_burstcount;
    logic [31:0]   bus_writedata;
    logic [29:0]   bus_address;
    logic          bus_write, bus_read;
    logic [3:0]    bus_byteenable;
    logic          s_waitrequest, s_readdatavalid, s_writeresponsevalid;
    logic [31:0]   s_readdata;
    logic [1:0]    s_response;

    burst_line_master #(.BURST_LEN(BL), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_byteenable(req_byteenable), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .bus_burstcount(bus_burstcount), .bus_writedata(bus_writedata),
        .bus_address(bus_address), .bus_write(bus_write), .bus_read(bus_read),
        .bus_byteenable(bus_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model and bus monitor
    logic [31:0] mem [64];
    logic [31:0] wr_log [4];
    int          wr_cyc [4];
    int          cyc = 0, rd_high_cnt = 0, rsp_pulses = 0, wr_cnt = 0;
    int          inj_err_beat = -1;
    int          rd_pend = 0, rd_idx = 0, rd_base = 0, wr_idx = 0;
    bit          stalled = 0, wr_rsp_pend = 0;

    initial begin
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        s_writeresponsevalid = 1'b0; s_response = 2'b00;
        forever begin
            @(posedge clk_i);
            cyc++;
            wr_rsp_pend = 0;
            if (!rst_ni) begin
                rd_pend = 0; wr_idx = 0; stalled = 0;
            end else begin
                if (bus_read)  rd_high_cnt++;
                if (rsp_valid) rsp_pulses++;
                if (bus_read && !s_waitrequest) begin
                    rd_pend = BL; rd_idx = 0; rd_base = int'(bus_address) - 'h400;
                end
                if (bus_write && !s_waitrequest) begin
                    int a;
                    a = int'(bus_address) - 'h400 + wr_idx;
                    for (int b = 0; b < 4; b++)
                        if (bus_byteenable[b]) mem[a][8*b +: 8] = bus_writedata[8*b +: 8];
                    if (wr_cnt < 4) begin
                        wr_log[wr_cnt] = bus_writedata;
                        wr_cyc[wr_cnt] = cyc;
                    end
                    wr_cnt++; wr_idx++; wr_rsp_pend = 1;
                end
                if (!bus_write) wr_idx = 0;
            end
            #1;
            s_readdatavalid = 1'b0; s_writeresponsevalid = 1'b0; s_response = 2'b00;
            if (rst_ni && rd_pend > 0) begin
                s_readdatavalid = 1'b1;
                s_readdata      = mem[rd_base + rd_idx];
                if (rd_idx == inj_err_beat) s_response = 2'b10;
                rd_idx++; rd_pend--;
            end
            if (rst_ni && wr_rsp_pend) s_writeresponsevalid = 1'b1;
            if (!rst_ni || !(bus_read || bus_write)) begin
                stalled = 0; s_waitrequest = 1'b0;
            end else if (int'(bus_address) < 'h400 || int'(bus_address) > 'h43F) begin
                s_waitrequest = 1'b1;
            end else if (!stalled) begin
                stalled = 1; s_waitrequest = 1'b1;
            end else begin
                s_waitrequest = 1'b0;
            end
        end
    end

    logic [29:0] acc_addr;
    logic [4:0]  acc_burst;

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [127:0] wd, output int lat, output logic err,
                          output logic [127:0] rdata);
        @(negedge clk_i);
        rd_high_cnt = 0; rsp_pulses = 0; wr_cnt = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_byteenable = be; req_wdata = wd;
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        acc_addr  = bus_address;
        acc_burst = bus_burstcount;
        lat = 0; err = 1'b0; rdata = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_i); #1;
            if (rsp_valid) begin
                lat = n; err = rsp_error; rdata = rsp_rdata;
                break;
            end
        end
        if (lat == 0) check("rsp_wait", 128'(rsp_valid), 128'(1));
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    int           lat;
    logic         err;
    logic [127:0] rdata;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33; mem[7] = 32'h44;
        rst_ni = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_byteenable = '0; req_wdata = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_error", 128'(rsp_error), 128'(0));
        check("rst_rsp_rdata", rsp_rdata, 128'(0));
        check("rst_bus_read", 128'(bus_read), 128'(0));
        check("rst_bus_write", 128'(bus_write), 128'(0));
        check("rst_bus_address", 128'(bus_address), 128'(0));
        check("rst_bus_writedata", 128'(bus_writedata), 128'(0));
        check("rst_bus_byteenable", 128'(bus_byteenable), 128'(0));
        check("rst_burstcount", 128'(bus_burstcount), 128'(4));
        @(negedge clk_i) rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Fill from 0x1010
        do_req(1'b0, 32'h1010, 4'hF, '0, lat, err, rdata);
        check("fill_addr", 128'(acc_addr), 128'(30'h404));
        check("fill_burst", 128'(acc_burst), 128'(4));
        check("fill_read_cycles", 128'(rd_high_cnt), 128'(2));
        check("fill_latency", 128'(lat), 128'(6));
        check("fill_rdata", rdata, {32'h44, 32'h33, 32'h22, 32'h11});
        check("fill_error", 128'(err), 128'(0));
        check("fill_pulses", 128'(rsp_pulses), 128'(1));
        check("fill_ready_again", 128'(req_ready), 128'(1));

        // Write-back to 0x1000
        do_req(1'b1, 32'h1000, 4'hF, {32'hD, 32'hC, 32'hB, 32'hA}, lat, err, rdata);
        check("wr_beats", 128'(wr_cnt), 128'(4));
        check("wr_beat0", 128'(wr_log[0]), 128'(32'hA));
        check("wr_beat1", 128'(wr_log[1]), 128'(32'hB));
        check("wr_beat2", 128'(wr_log[2]), 128'(32'hC));
        check("wr_beat3", 128'(wr_log[3]), 128'(32'hD));
        check("wr_consecutive", 128'(wr_cyc[3] - wr_cyc[0]), 128'(3));
        check("wr_latency", 128'(lat), 128'(6));
        check("wr_error", 128'(err), 128'(0));
        check("wr_pulses", 128'(rsp_pulses), 128'(1));
        do_req(1'b0, 32'h1000, 4'hF, '0, lat, err, rdata);
        check("wr_readback", rdata, {32'hD, 32'hC, 32'hB, 32'hA});

        // Partial byteenable over zeroed words at 0x1020
        do_req(1'b1, 32'h1020, 4'b0011, {4{32'hFFFF_FFFF}}, lat, err, rdata);
        check("part_wr_error", 128'(err), 128'(0));
        do_req(1'b0, 32'h1020, 4'hF, '0, lat, err, rdata);
        check("part_readback", rdata, {4{32'h0000_FFFF}});

        // Unmapped address: watchdog abort
        do_req(1'b0, 32'h8000, 4'hF, '0, lat, err, rdata);
        check("to_read_cycles", 128'(rd_high_cnt), 128'(16));
        check("to_latency", 128'(lat), 128'(16));
        check("to_error", 128'(err), 128'(1));
        check("to_bus_read_low", 128'(bus_read), 128'(0));

        // Error response on the third read beat
        inj_err_beat = 2;
        do_req(1'b0, 32'h1010, 4'hF, '0, lat, err, rdata);
        inj_err_beat = -1;
        check("inj_rdata", rdata, {32'h44, 32'h33, 32'h22, 32'h11});
        check("inj_error", 128'(err), 128'(1));

        // Reset during the second write beat
        @(negedge clk_i);
        rsp_pulses = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000; req_byteenable = 4'hF;
        req_wdata = {32'h8, 32'h7, 32'h6, 32'h5};
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_mid_pre_wdata", 128'(bus_writedata), 128'(32'h6));
        check("rst_mid_pre_write", 128'(bus_write), 128'(1));
        rst_ni = 1'b0;
        #1;
        check("rst_mid_write_low", 128'(bus_write), 128'(0));
        check("rst_mid_read_low", 128'(bus_read), 128'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("rst_mid_no_rsp", 128'(rsp_pulses), 128'(0));
        check("rst_mid_ready", 128'(req_ready), 128'(1));
        do_req(1'b1, 32'h1000, 4'hF, {32'h4, 32'h3, 32'h2, 32'h1}, lat, err, rdata);
        check("after_rst_latency", 128'(lat), 128'(6));
        check("after_rst_error", 128'(err), 128'(0));
        check("after_rst_pulses", 128'(rsp_pulses), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
